msrv32_pc_gen: RTL and testbench
================================

MSRV32_PC_GEN -- requirements
Module: msrv32_pc_gen

Interface
REQ-001 SHALL have parameter BOOT_ADDRESS, default 32'h0000_0000: PC value after reset and for pc_src_in=00.
REQ-002 SHALL have port ms_riscv32_mp_clk_in, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port ms_riscv32_mp_rst_in, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port pc_src_in, input, 2: next-PC source; 00 boot, 01 epc, 10 trap, 11 sequential/branch.
REQ-005 SHALL have port branch_taken_in, input, 1: taken indication from the branch unit (branch, JAL, JALR).
REQ-006 SHALL have port iaddr_in, input, 32: branch/jump target computed by the ALU.
REQ-007 SHALL have port epc_in, input, 32: return address for MRET.
REQ-008 SHALL have port trap_address_in, input, 32: trap vector target.
REQ-009 SHALL have port ahb_ready_in, input, 1: instruction bus ready; low stalls the PC.
REQ-010 SHALL have port pc_out, output, 32: PC of the instruction in execute.
REQ-011 SHALL have port pc_plus_4_out, output, 32: pc_out+4, link value for JAL/JALR.
REQ-012 SHALL have port i_addr_out, output, 32: fetch address presented to the bus.
REQ-013 SHALL have port flush_out, output, 1: squash the fetched instruction.
REQ-014 SHALL have port misaligned_instr_out, output, 1: taken target not 4-byte aligned.

Function
REQ-015 target_c SHALL be {iaddr_in[31:1],1'b0}; pc_plus_4_out SHALL equal pc_out+32'd4, modulo 2^32 (FFFF_FFFC wraps to 0000_0000).
REQ-016 next_pc SHALL be: BOOT_ADDRESS for 00; epc_in for 01; trap_address_in for 10; target_c if branch_taken_in else pc_plus_4_out for 11.
REQ-017 redirect SHALL be defined as pc_src_in!=11, or (pc_src_in==11 and branch_taken_in).
REQ-018 State machine SHALL have states BOOT, RUN and HOLD.
REQ-019 BOOT SHALL last exactly one cycle after reset release, assert flush_out=1 and hold pc_out; the next state SHALL be RUN.
REQ-020 RUN with ahb_ready_in=1 SHALL present i_addr_out=next_pc combinationally and load pc_out<=next_pc at the edge (zero-cycle fetch latency, one-cycle PC update).
REQ-021 RUN with ahb_ready_in=0 SHALL hold pc_out, drive i_addr_out=pc_out, and leave pc_out unchanged.
REQ-022 If a redirect occurs in RUN with ahb_ready_in=0, the block SHALL latch next_pc into a pending register and move to HOLD.
REQ-023 In HOLD, i_addr_out SHALL equal the pending register and pc_out SHALL hold.
REQ-024 In HOLD, a new redirect SHALL overwrite the pending register; with pc_src_in 10/01, trap/epc SHALL win over a simultaneous branch.
REQ-025 HOLD with ahb_ready_in=1 SHALL load pc_out<=pending and return to RUN; an external redirect in that same cycle SHALL take priority over pending.
REQ-026 flush_out SHALL be 1 for exactly the one cycle following any accepted redirect, and 0 otherwise (except BOOT).
REQ-027 misaligned_instr_out SHALL be combinational and equal 1 only when pc_src_in==11, branch_taken_in=1 and target_c[1]=1.
REQ-028 While misaligned_instr_out=1, pc_out SHALL not update and no flush SHALL be raised; the trap path redirects on a later cycle.

Reset
REQ-029 With ms_riscv32_mp_rst_in=1 at an edge, the block SHALL set pc_out=BOOT_ADDRESS, the pending register=0, state=BOOT and flush_out=0.
REQ-030 While reset is asserted, i_addr_out SHALL equal BOOT_ADDRESS.
REQ-031 Reset SHALL override any stall, pending redirect or HOLD state.

Configuration
REQ-032 With macro MSRV32_MISALIGN_TRAP_EN defined, REQ-027/028 SHALL apply.
REQ-033 Without MSRV32_MISALIGN_TRAP_EN, target_c SHALL be {iaddr_in[31:2],2'b00}, misaligned_instr_out SHALL be tied 0, and branches SHALL always redirect.

Verification
REQ-034 Scenario: reset with BOOT_ADDRESS=0, release, ready=1, src=11, no branch -> flush=1 in BOOT, then pc_out 0,4,8,C on successive cycles.
REQ-035 Scenario: pc_out=0x100, branch_taken=1, iaddr_in=0x201 (macro off) -> i_addr_out=0x200 same cycle, pc_out=0x200 next cycle, flush_out=1 one cycle.
REQ-036 Scenario: ready=0 with branch to 0x300, then 2 stall cycles, then ready=1 -> i_addr_out=0x300 throughout HOLD, pc_out=0x300 after ready.
REQ-037 Scenario: in HOLD (pending 0x300), src=10 with trap_address_in=0x80 -> pending overwritten, pc_out=0x80 after ready.
REQ-038 Scenario: macro on, branch_taken=1, iaddr_in=0x102 -> misaligned_instr_out=1, pc_out unchanged, flush_out=0.
REQ-039 Scenario: pc_out=0xFFFF_FFFC, sequential step -> pc_out=0x0000_0000; reset asserted mid-HOLD -> pc_out=BOOT_ADDRESS and state BOOT.

Source files
------------

// File: rtl/msrv32_pc_gen.sv
// msrv32_pc_gen: program counter generator for the MSRV32 core.
// Chooses the next PC from boot, MRET, trap and branch/sequential sources.
// Stalls on instruction-bus backpressure and parks a redirect seen
// during a stall until the bus accepts it.
// Optional feature macro: MSRV32_MISALIGN_TRAP_EN. When it is defined,
// a taken branch to a target that is not 4-byte aligned is reported
// and suppressed. When it is not defined, targets are forced to word
// alignment.
module msrv32_pc_gen #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [1:0]  pc_src_in,
    input  logic        branch_taken_in,
    input  logic [31:0] iaddr_in,
    input  logic [31:0] epc_in,
    input  logic [31:0] trap_address_in,
    input  logic        ahb_ready_in,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus_4_out,
    output logic [31:0] i_addr_out,
    output logic        flush_out,
    output logic        misaligned_instr_out
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_q, pending_d;
    logic        flush_q, flush_d;
    logic [31:0] target_c;
    logic [31:0] next_pc;
    logic [31:0] i_addr_c;
    logic        redirect;
    logic        misaligned;

`ifdef MSRV32_MISALIGN_TRAP_EN
    // Clear only bit 0; bit 1 stays visible so misalignment can be detected.
    assign target_c   = iaddr_in & 32'hFFFF_FFFE;
    assign misaligned = (pc_src_in == 2'b11) & branch_taken_in & target_c[1];
`else
    // Force word alignment; a taken branch always redirects.
    assign target_c   = iaddr_in & 32'hFFFF_FFFC;
    assign misaligned = 1'b0;
`endif

    assign pc_plus_4_out = pc_q + 32'd4;

    // Anything other than a sequential step is a change of flow.
    assign redirect = (pc_src_in != 2'b11) | branch_taken_in;

    // Select the next PC from the requested source.
    always_comb begin
        next_pc = pc_plus_4_out;
        case (pc_src_in)
            2'b00:   next_pc = BOOT_ADDRESS;
            2'b01:   next_pc = epc_in;
            2'b10:   next_pc = trap_address_in;
            default: next_pc = branch_taken_in ? target_c : pc_plus_4_out;
        endcase
    end

    // Next-state, PC update, pending capture and fetch address.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        flush_d   = 1'b0;
        i_addr_c  = pc_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                // A misaligned branch freezes the PC; the trap follows later.
                if (!misaligned) begin
                    if (ahb_ready_in) begin
                        i_addr_c = next_pc;
                        pc_d     = next_pc;
                        flush_d  = redirect;
                    end else if (redirect) begin
                        pending_d = next_pc;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                i_addr_c = pending_q;
                if (!misaligned) begin
                    if (ahb_ready_in) begin
                        // A fresh redirect in the release cycle beats the parked one.
                        state_d = RUN;
                        flush_d = 1'b1;
                        if (redirect) begin
                            i_addr_c = next_pc;
                            pc_d     = next_pc;
                        end else begin
                            pc_d = pending_q;
                        end
                    end else if (redirect) begin
                        pending_d = next_pc;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        if (ms_riscv32_mp_rst_in) begin
            i_addr_c = BOOT_ADDRESS;
        end
    end

    // State and PC registers with synchronous reset.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q   <= BOOT;
            pc_q      <= BOOT_ADDRESS;
            pending_q <= 32'h0000_0000;
            flush_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            flush_q   <= flush_d;
        end
    end

    assign pc_out               = pc_q;
    assign i_addr_out           = i_addr_c;
    assign flush_out            = flush_q | ((state_q == BOOT) & ~ms_riscv32_mp_rst_in);
    assign misaligned_instr_out = misaligned;

endmodule

// File: tb/tb_msrv32_pc_gen.sv
// tb_msrv32_pc_gen: directed bench for msrv32_pc_gen with a scoreboard queue.
// The driver pushes the expected outputs for each cycle it drives.
// The monitor pops each entry and compares it on the falling edge.
module tb_msrv32_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  src;
    logic        br;
    logic [31:0] iaddr;
    logic [31:0] epc;
    logic [31:0] trap;
    logic        rdy;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_4_out;
    logic [31:0] i_addr_out;
    logic        flush_out;
    logic        mis_out;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] ia;
        logic        fl;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    msrv32_pc_gen #(.BOOT_ADDRESS(32'h0000_0000)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .pc_src_in            (src),
        .branch_taken_in      (br),
        .iaddr_in             (iaddr),
        .epc_in               (epc),
        .trap_address_in      (trap),
        .ahb_ready_in         (rdy),
        .pc_out               (pc_out),
        .pc_plus_4_out        (pc_plus_4_out),
        .i_addr_out           (i_addr_out),
        .flush_out            (flush_out),
        .misaligned_instr_out (mis_out)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the rising edge and queue its expectation.
    task automatic step(input logic r, input logic [1:0] s, input logic b,
                        input logic [31:0] ia, input logic rd, input logic chk,
                        input string nm, input logic [31:0] e_pc,
                        input logic [31:0] e_ia, input logic e_fl, input logic e_mis);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; src = s; br = b; iaddr = ia; rdy = rd;
        if (chk) begin
            e.name = nm; e.pc = e_pc; e.ia = e_ia; e.fl = e_fl; e.mis = e_mis;
            sb_q.push_back(e);
        end
    endtask

    // Monitor: compare every queued expectation on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (pc_out !== e.pc || pc_plus_4_out !== (e.pc + 32'd4) ||
                    i_addr_out !== e.ia || flush_out !== e.fl || mis_out !== e.mis) begin
                    n_fail++;
                    $display("FAIL %s: got pc=%h pc4=%h ia=%h fl=%b mis=%b, want pc=%h pc4=%h ia=%h fl=%b mis=%b",
                             e.name, pc_out, pc_plus_4_out, i_addr_out, flush_out, mis_out,
                             e.pc, e.pc + 32'd4, e.ia, e.fl, e.mis);
                end
            end
        end
    end

    initial begin
        logic [31:0] base;
        logic        base_fl;
        rst = 1'b1; src = 2'b11; br = 1'b0; iaddr = 32'h0; rdy = 1'b0;
        epc = 32'h0000_0040; trap = 32'h0000_0080;

        // Reset, boot and sequential fetch
        step(1, 2'b11, 1, 32'h500, 0, 0, "rst0", 32'h0, 32'h0, 0, 0);
        step(1, 2'b11, 1, 32'h500, 0, 1, "rst_held", 32'h0, 32'h0, 0, 0);
        step(0, 2'b11, 0, 32'h0, 1, 1, "boot", 32'h0, 32'h0, 1, 0);
        step(0, 2'b11, 0, 32'h0, 1, 1, "seq0", 32'h0, 32'h4, 0, 0);
        step(0, 2'b11, 0, 32'h0, 1, 1, "seq4", 32'h4, 32'h8, 0, 0);
        step(0, 2'b11, 0, 32'h0, 1, 1, "seq8", 32'h8, 32'hC, 0, 0);
        step(0, 2'b11, 0, 32'h0, 1, 1, "seqC", 32'hC, 32'h10, 0, 0);
        step(0, 2'b11, 1, 32'h100, 1, 1, "br100", 32'h10, 32'h100, 0, 0);
        // Branch with bit 0 set in the target
        step(0, 2'b11, 1, 32'h201, 1, 1, "br201", 32'h100, 32'h200, 1, 0);
        step(0, 2'b11, 0, 32'h0, 1, 1, "at200", 32'h200, 32'h204, 1, 0);
        // Redirect during a stall, two stall cycles, then release
        step(0, 2'b11, 1, 32'h300, 0, 1, "stall_br", 32'h204, 32'h204, 0, 0);
        step(0, 2'b11, 0, 32'h0, 0, 1, "hold1", 32'h204, 32'h300, 0, 0);
        step(0, 2'b11, 0, 32'h0, 0, 1, "hold2", 32'h204, 32'h300, 0, 0);
        step(0, 2'b11, 0, 32'h0, 1, 1, "hold_rel", 32'h204, 32'h300, 0, 0);
        step(0, 2'b11, 0, 32'h0, 1, 1, "at300", 32'h300, 32'h304, 1, 0);
        // A trap overwrites the parked branch
        step(0, 2'b11, 1, 32'h300, 0, 1, "stall_br2", 32'h304, 32'h304, 0, 0);
        step(0, 2'b10, 1, 32'h400, 0, 1, "hold_trap", 32'h304, 32'h300, 0, 0);
        step(0, 2'b11, 0, 32'h0, 0, 1, "hold_80", 32'h304, 32'h80, 0, 0);
        step(0, 2'b11, 0, 32'h0, 1, 1, "rel_80", 32'h304, 32'h80, 0, 0);
        // MRET path
        step(0, 2'b01, 0, 32'h0, 1, 1, "epc", 32'h80, 32'h40, 1, 0);
        // Branch target with bit 1 set
`ifdef MSRV32_MISALIGN_TRAP_EN
        step(0, 2'b11, 1, 32'h102, 1, 1, "mis102", 32'h40, 32'h40, 1, 1);
        base = 32'h40; base_fl = 1'b0;
`else
        step(0, 2'b11, 1, 32'h102, 1, 1, "mis102", 32'h40, 32'h100, 1, 0);
        base = 32'h100; base_fl = 1'b1;
`endif
        step(0, 2'b11, 0, 32'h0, 1, 1, "after_mis", base, base + 32'd4, base_fl, 0);
        // Wrap of the PC at the top of the address space
        step(0, 2'b11, 1, 32'hFFFF_FFFC, 1, 1, "br_top", base + 32'd4, 32'hFFFF_FFFC, 0, 0);
        step(0, 2'b11, 0, 32'h0, 1, 1, "wrap", 32'hFFFF_FFFC, 32'h0, 1, 0);
        step(0, 2'b11, 0, 32'h0, 1, 1, "at0", 32'h0, 32'h4, 0, 0);
        // Reset while in HOLD
        step(0, 2'b11, 1, 32'h700, 0, 1, "stall_br3", 32'h4, 32'h4, 0, 0);
        step(0, 2'b11, 0, 32'h0, 0, 1, "hold700", 32'h4, 32'h700, 0, 0);
        step(1, 2'b11, 0, 32'h0, 0, 1, "rst_hold", 32'h4, 32'h0, 0, 0);
        step(0, 2'b11, 0, 32'h0, 1, 1, "boot2", 32'h0, 32'h0, 1, 0);
        step(0, 2'b11, 0, 32'h0, 1, 1, "run2", 32'h0, 32'h4, 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d entries left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
